// File: rtl/hc_queue_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// hc_arb_pkg
//   Shared definitions for the hybrid-cache queue arbiter:
//   - drain-controller state encoding (RUN / DRAIN / DRAINED, 2 bits)
//   - FIFO warning offset (warning asserts at level >= depth + 1 - offset)
//   - helper deriving the requester id width from the requester count
// ---------------------------------------------------------------------------
package hc_arb_pkg;

  // Drain-controller state encoding, kept as plain constants so the state
  // register stays a bare logic vector that older tooling can probe.
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] DRAINED = 2'd2;

  // One staged entry can still land after the grant that raised the level,
  // so the warning sits a few entries below full.
  localparam int FIFO_WARN_OFFSET = 3;

  // Requester id width; at least one bit even for the smallest arbiter.
  function automatic int id_bits(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/hc_queue_arbiter_myqueue.sv
// ---------------------------------------------------------------------------
// myqueue
//   Pointer-based synchronous FIFO with 2**CNTBITS slots, one of which is
//   kept free to tell full from empty (usable depth 2**CNTBITS-1). The head
//   entry is presented combinationally on pop_data.
//
//   clk, reset_n  clock, asynchronous active-low reset (pointers only)
//   push          write push_data this cycle (ignored when full)
//   push_data     entry to write
//   pop           retire the head entry this cycle (ignored when empty)
//   pop_data      current head entry
//   not_empty     at least one entry stored
//   warning       level >= 2**CNTBITS - WARN_OFFSET
// ---------------------------------------------------------------------------
module myqueue #(
  parameter int DATABITS    = 34,
  parameter int CNTBITS     = 4,
  parameter int WARN_OFFSET = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic [DATABITS-1:0] push_data,
  input  logic                pop,
  output logic [DATABITS-1:0] pop_data,
  output logic                not_empty,
  output logic                warning
);

  localparam int DEPTH = 2 ** CNTBITS;

  logic [DATABITS-1:0] mem [DEPTH];
  logic [CNTBITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNTBITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTBITS-1:0]  level;
  logic                full;
  logic                do_push;
  logic                do_pop;

  always_comb begin
    // Pointer difference wraps naturally in CNTBITS bits.
    level     = wr_ptr_q - rd_ptr_q;
    full      = (level == CNTBITS'(DEPTH - 1));
    not_empty = (level != '0);
    warning   = (level >= CNTBITS'(DEPTH - WARN_OFFSET));
    do_push   = push & ~full;
    do_pop    = pop & not_empty;
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pop_data  = mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; clearing the pointers
  // already makes every slot invisible, and a reset on the array would turn
  // cheap RAM into a wide bank of resettable flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/hc_queue_arbiter.sv
// ---------------------------------------------------------------------------
// hc_queue_arbiter
//   Round-robin arbiter sharing one command FIFO among NREQ requesters.
//   A winner is picked each cycle among requesters whose request is high and
//   whose ack is not already high; the winner is acked and its {id,data}
//   is captured into a stage register, which pushes into the FIFO on the
//   following edge. Grants pause while the FIFO warning is up. The FIFO
//   drains to one downstream valid/ready port. A drain controller stops
//   accepting on drain_req and reports drain_done once the block is empty.
//
//   clk, reset_n  clock, asynchronous active-low reset
//   req           per-requester request level, held until its ack
//   req_data      packed payloads, slice i belongs to requester i
//   ack           registered one-cycle accept pulse (at most one bit set)
//   out_valid     FIFO holds at least one entry
//   out_data      payload at FIFO head
//   out_id        requester id at FIFO head
//   out_ready     downstream takes the head this cycle
//   drain_req     level request to stop accepting and empty the block
//   drain_done    registered; block empty and accepting nothing
//   busy          stage entry in flight or FIFO not empty
// ---------------------------------------------------------------------------
module hc_queue_arbiter
  import hc_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int IDBITS       = id_bits(NREQ),
  parameter int DATABITS     = 32,
  parameter int QUEUECNTBITS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATABITS-1:0] req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     out_valid,
  output logic [DATABITS-1:0]      out_data,
  output logic [IDBITS-1:0]        out_id,
  input  logic                     out_ready,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     busy
);

  localparam int             ENTRYBITS = DATABITS + IDBITS;
  localparam logic [IDBITS:0] NREQ_W   = (IDBITS + 1)'(NREQ);
  localparam logic [IDBITS-1:0] LAST_ID = IDBITS'(NREQ - 1);

  // First set bit of mask, searching ptr, ptr+1, ... modulo NREQ. The sum
  // carries one extra bit so the wrap is an explicit compare and works for
  // requester counts that are not a power of two.
  function automatic logic [IDBITS-1:0] rr_pick(input logic [NREQ-1:0]   mask,
                                                input logic [IDBITS-1:0] ptr);
    logic [IDBITS:0]   sum;
    logic [IDBITS-1:0] pick;
    logic              found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDBITS + 1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && mask[sum[IDBITS-1:0]]) begin
        pick  = sum[IDBITS-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [DATABITS-1:0] req_data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_data_arr[g] = req_data[g*DATABITS +: DATABITS];
  end

  logic [NREQ-1:0]     ack_q, ack_d;
  logic                stage_valid_q, stage_valid_d;
  logic [DATABITS-1:0] stage_data_q, stage_data_d;
  logic [IDBITS-1:0]   stage_id_q, stage_id_d;
  logic [IDBITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]          state_q, state_d;
  logic                drain_done_q, drain_done_d;

  logic [NREQ-1:0]     elig;
  logic [IDBITS-1:0]   win;
  logic                grant;
  logic                fifo_push;
  logic                fifo_pop;
  logic [ENTRYBITS-1:0] fifo_in;
  logic [ENTRYBITS-1:0] fifo_out;
  logic                fifo_not_empty;
  logic                fifo_warning;

  // Accept path. A requester whose ack is high this cycle still shows its
  // request (it drops it only after seeing the ack), so it is masked out to
  // avoid accepting the same command twice.
  // NOTE: combinational blocks use blocking assignments with every output
  // defaulted first, so no path leaves a value held and no latch is inferred;
  // the flops below are the only place state is kept, written with <=.
  always_comb begin
    elig  = req & ~ack_q;
    win   = rr_pick(elig, rr_ptr_q);
    grant = (state_q == RUN) & ~drain_req & ~fifo_warning & (|elig);

    ack_d         = '0;
    stage_valid_d = 1'b0;
    stage_data_d  = stage_data_q;
    stage_id_d    = stage_id_q;
    rr_ptr_d      = rr_ptr_q;

    if (grant) begin
      ack_d[win]    = 1'b1;
      stage_valid_d = 1'b1;
      stage_data_d  = req_data_arr[win];
      stage_id_d    = win;
      rr_ptr_d      = (win == LAST_ID) ? '0 : win + 1'b1;
    end
  end

  // Drain controller. Leaving DRAIN early on a dropped request is safe: the
  // FIFO and stage keep their contents and simply continue draining in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!drain_req)                            state_d = RUN;
        else if (!stage_valid_q && !fifo_not_empty) state_d = DRAINED;
      end
      DRAINED: begin
        if (!drain_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    drain_done_d = (state_d == DRAINED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q         <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_id_q    <= '0;
      rr_ptr_q      <= '0;
      state_q       <= RUN;
      drain_done_q  <= 1'b0;
    end else begin
      ack_q         <= ack_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      stage_id_q    <= stage_id_d;
      rr_ptr_q      <= rr_ptr_d;
      state_q       <= state_d;
      drain_done_q  <= drain_done_d;
    end
  end

  // FIFO side: the stage register feeds the FIFO unconditionally; the
  // warning threshold guarantees room for the one entry still in flight.
  assign fifo_push = stage_valid_q;
  assign fifo_in   = {stage_id_q, stage_data_q};
  assign fifo_pop  = out_valid & out_ready;

  myqueue #(
    .DATABITS    (ENTRYBITS),
    .CNTBITS     (QUEUECNTBITS),
    .WARN_OFFSET (FIFO_WARN_OFFSET)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .not_empty (fifo_not_empty),
    .warning   (fifo_warning)
  );

  assign ack        = ack_q;
  assign out_valid  = fifo_not_empty;
  assign out_data   = fifo_out[DATABITS-1:0];
  assign out_id     = fifo_out[DATABITS +: IDBITS];
  assign drain_done = drain_done_q;
  assign busy       = stage_valid_q | fifo_not_empty;

endmodule

// File: tb/tb_hc_queue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hc_queue_arbiter
//   Directed bench for hc_queue_arbiter (NREQ=4, DATABITS=32, depth 15).
//   A cycle table covers single-requester latency, round-robin pointer
//   movement and the same-cycle ack mask; hand-written sequences cover
//   fairness, FIFO backpressure, drain and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_hc_queue_arbiter;

  localparam int NREQ     = 4;
  localparam int IDBITS   = 2;
  localparam int DATABITS = 32;

  logic                     clk;
  logic                     reset_n;
  logic [NREQ-1:0]          req;
  logic [NREQ*DATABITS-1:0] req_data;
  logic [NREQ-1:0]          ack;
  logic                     out_valid;
  logic [DATABITS-1:0]      out_data;
  logic [IDBITS-1:0]        out_id;
  logic                     out_ready;
  logic                     drain_req;
  logic                     drain_done;
  logic                     busy;

  hc_queue_arbiter #(
    .NREQ         (NREQ),
    .IDBITS       (IDBITS),
    .DATABITS     (DATABITS),
    .QUEUECNTBITS (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed payload per requester; requester 2 carries 0xA5A5_0001.
  logic [31:0] data_arr [NREQ];
  assign req_data = {data_arr[3], data_arr[2], data_arr[1], data_arr[0]};

  int total;
  int bad;
  int acks;
  int pops;
  int sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int id_of(input logic [NREQ-1:0] a);
    int r;
    r = 0;
    for (int i = NREQ - 1; i >= 0; i--) if (a[i]) r = i;
    return r;
  endfunction

  // One clock: check the popped head against the scoreboard before the edge,
  // then record any ack after the edge.
  task automatic cycle();
    if (out_valid && out_ready) begin
      pops++;
      check("pop_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check("pop_id",   64'(out_id),   64'(sb[0]));
        check("pop_data", 64'(out_data), 64'(data_arr[sb[0]]));
        void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (ack != '0) begin
      check("ack_onehot", 64'($onehot(ack)), 64'd1);
      sb.push_back(id_of(ack));
      acks++;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",        64'(ack),        64'd0);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_drain_done", 64'(drain_done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic            rdy;
    logic [NREQ-1:0] exp_ack;
    logic            exp_valid;
    logic            chk_head;
    logic [1:0]      exp_id;
    logic [31:0]     exp_data;
    logic            exp_busy;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int n;
    int n_after;
    total = 0;
    bad   = 0;
    acks  = 0;
    pops  = 0;
    data_arr[0] = 32'h1000_00C0;
    data_arr[1] = 32'h1111_1111;
    data_arr[2] = 32'hA5A5_0001;
    data_arr[3] = 32'h3333_3333;

    // Inputs for one cycle, then outputs expected just after that edge.
    //           req      rdy   ack      vld   head  id     data           busy
    vecs[0] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 32'h0,          1'b1};
    vecs[1] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 32'hA5A5_0001,  1'b1};
    vecs[2] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0,          1'b0};
    vecs[3] = '{4'b1001, 1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 32'h0,          1'b1};
    vecs[4] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd3, 32'h3333_3333,  1'b1};
    vecs[5] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 32'h1000_00C0,  1'b1};
    vecs[6] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0,          1'b0};
    vecs[7] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 32'h0,          1'b1};
    vecs[8] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 32'h1111_1111,  1'b1};
    vecs[9] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0,          1'b0};

    do_reset();

    // ---- table: latency, rr pointer wrap, same-cycle ack mask ----
    for (int i = 0; i < 10; i++) begin
      req       = vecs[i].req;
      out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ack", i),   64'(ack),        64'(vecs[i].exp_ack));
      check($sformatf("v%0d_valid", i), 64'(out_valid),  64'(vecs[i].exp_valid));
      check($sformatf("v%0d_busy", i),  64'(busy),       64'(vecs[i].exp_busy));
      check($sformatf("v%0d_done", i),  64'(drain_done), 64'd0);
      if (vecs[i].chk_head) begin
        check($sformatf("v%0d_id", i),   64'(out_id),   64'(vecs[i].exp_id));
        check($sformatf("v%0d_data", i), 64'(out_data), 64'(vecs[i].exp_data));
      end
    end

    // ---- fairness and steady push/pop ----
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      check($sformatf("fair_ack%0d", k), 64'(ack), 64'(4'b0001 << (k % 4)));
      if (k >= 1) check($sformatf("fair_valid%0d", k), 64'(out_valid), 64'd1);
    end

    // ---- backpressure: warning throttles at 13, 14 entries end up queued ----
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b0;
    n = 0;
    repeat (30) begin
      cycle();
      if (ack != '0) n++;
    end
    check("bp_acks", 64'(n), 64'd14);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_head_id", 64'(out_id), 64'd0);
    out_ready = 1'b1;
    pops = 0;
    n_after = 0;
    repeat (20) begin
      cycle();
      if (ack != '0) n_after++;
    end
    check("bp_resume", 64'(n_after != 0), 64'd1);
    check("bp_pops", 64'(pops >= 14), 64'd1);
    req = '0;
    n = 0;
    while ((out_valid || busy) && n < 40) begin
      cycle();
      n++;
    end
    check("bp_emptied", 64'(busy), 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // ---- drain with 5 queued entries ----
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b0;
    acks = 0;
    n = 0;
    while (acks < 5 && n < 20) begin
      cycle();
      n++;
    end
    check("drain_fill_acks", 64'(acks), 64'd5);
    drain_req = 1'b1;
    repeat (3) begin
      cycle();
      check("drain_no_ack", 64'(ack), 64'd0);
      check("drain_not_done", 64'(drain_done), 64'd0);
    end
    check("drain_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("drain_pop%0d_valid", k), 64'(out_valid), 64'(k < 4));
      check($sformatf("drain_pop%0d_done", k), 64'(drain_done), 64'd0);
      check($sformatf("drain_pop%0d_ack", k), 64'(ack), 64'd0);
    end
    cycle();
    check("drain_done_set", 64'(drain_done), 64'd1);
    check("drain_idle", 64'(busy), 64'd0);
    drain_req = 1'b0;
    cycle();
    check("undrain_done_clr", 64'(drain_done), 64'd0);
    check("undrain_ack0", 64'(ack), 64'd0);
    cycle();
    check("undrain_ack_resume", 64'(ack), 64'b0010);

    // ---- asynchronous reset mid-burst ----
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b0;
    repeat (3) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ack",        64'(ack),        64'd0);
    check("arst_out_valid",  64'(out_valid),  64'd0);
    check("arst_busy",       64'(busy),       64'd0);
    check("arst_drain_done", 64'(drain_done), 64'd0);
    sb.delete();
    req = 4'b1010;
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    check("arst_first_grant", 64'(ack), 64'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
